rv_mem: RTL

- Unified instruction/data memory for the multicycle RISC-V core; sits downstream of the control plane and datapath.
- Consumes the memory address, write data and memrw strobe; produces the read word that feeds IR (FETCH) and MDR (LW_MEM).
- Models a slow memory: every access takes a parameterised number of wait cycles.
- The control plane must hold its current state while stall is high.

---
 rtl/rv_mem.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rv_mem.sv
// Unified instruction/data memory for the multicycle RISC-V core, modelling a slow single-port array.
// Latency: request at cycle N, stall high N..N+LATENCY, rdata valid with stall low at N+LATENCY+1.
// Backpressure: stall is asserted combinationally from memen in IDLE and held high through BUSY.
//
// Ports:
//   clk, rst        core clock (rising edge), asynchronous active-high reset
//   memen, memrw    access request and direction (1 = write), sampled together in IDLE
//   addr, wdata     byte address (word index = addr[log2(MEM_WORDS)+1:2]) and write data
//   rdata           registered read word, held until the next completed read
//   stall           high while an accepted or newly presented request is incomplete
//   fault           (only with RV_MEM_FAULT_EN) sticky flag for misaligned or out-of-range accesses
//
// Optional feature macro: RV_MEM_FAULT_EN adds the sticky fault output.

module rv_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen,
    input  logic        memrw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall
`ifdef RV_MEM_FAULT_EN
    ,
    output logic        fault
`endif
);

    localparam int IDXW = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Wait counter is 4 bits wide, which covers the legal LATENCY range 1..15.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_memrw;
    logic [31:0] r_rdata;

    logic [31:0] r_mem [MEM_WORDS];

    logic [IDXW-1:0] w_idx;
    logic            w_oor;
    logic            w_commit;
    logic            w_wr_en;
    logic            w_stall;

    // All address decoding works on the latched request; live inputs are
    // ignored once the access has been accepted.
    assign w_idx    = r_addr[IDXW+1:2];
    assign w_oor    = |r_addr[31:IDXW+2];

    // The access happens on the edge that leaves BUSY.
    assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // Out-of-range writes are dropped rather than aliased onto the array.
    assign w_wr_en  = w_commit && r_memrw && !w_oor;

    // In IDLE the stall follows memen combinationally so the control plane
    // freezes in the very cycle it presents the request. DONE reports
    // stall low so IR/MDR are captured on that edge.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = memen;
            S_BUSY:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign stall = w_stall;
    assign rdata = r_rdata;

    // Array storage has no reset. A reset during BUSY forces the FSM to IDLE
    // asynchronously, so w_wr_en is already low at the next clock edge and
    // the pending write never lands.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_memrw <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (memen) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_memrw <= memrw;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_memrw) begin
                            r_rdata <= w_oor ? 32'd0 : r_mem[w_idx];
                        end
                        r_state <= S_DONE;
                    end
                end

                // memen still high here is the tail of the request just
                // completed; it must not start a second access.
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RV_MEM_FAULT_EN
    logic r_fault;

    // Sticky: set on the BUSY exit of a misaligned or out-of-range request,
    // cleared only by reset. The access itself proceeds as usual.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_commit && (w_oor || (r_addr[1:0] != 2'b00))) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`else
    // Byte-offset bits only matter for fault reporting.
    logic w_unused_lsb;
    assign w_unused_lsb = ^r_addr[1:0];
`endif

endmodule
